// File: rtl/display_7seg_scan.sv
// ============================================================================
// display_7seg_scan : N-digit multiplexed 7-segment driver with double-buffered
//                     load, dead-time blanking and leading-zero suppression.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_7seg_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 10000,
  parameter int DEAD_CYCLES = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] dato_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  ce_i,
  input  logic                  blank_lz_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int unsigned c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIGITS - 1);
  localparam logic [c_cnt_w-1:0] c_dead     = c_cnt_w'(DEAD_CYCLES);
  localparam logic               c_pol      = (ACTIVE_LOW != 0);

  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [c_idx_w-1:0]    idx_q, idx_d;
  logic                  first_q, first_d;
  logic [4*N_DIGITS-1:0] pend_dat_q, pend_dat_d, disp_dat_q, disp_dat_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  wrap, frame_start, active_window, lz_run;
  logic [N_DIGITS-1:0]   blank, an_act;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [6:0]            seg_act;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'b0111111;
      4'h1: hex_to_seg = 7'b0000110;
      4'h2: hex_to_seg = 7'b1011011;
      4'h3: hex_to_seg = 7'b1001111;
      4'h4: hex_to_seg = 7'b1100110;
      4'h5: hex_to_seg = 7'b1101101;
      4'h6: hex_to_seg = 7'b1111101;
      4'h7: hex_to_seg = 7'b0000111;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1101111;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b1111100;
      4'hC: hex_to_seg = 7'b0111001;
      4'hD: hex_to_seg = 7'b1011110;
      4'hE: hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    wrap        = (cnt_q == c_cnt_last);
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    if (wrap) idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
    // First cycle out of reset counts as a frame start so frame_o fires promptly.
    frame_start = first_q | (wrap & (idx_q == c_idx_last));
    first_d     = 1'b0;
    frame_d     = frame_start;
    pend_dat_d  = ce_i ? dato_i : pend_dat_q;
    pend_dp_d   = ce_i ? dp_i   : pend_dp_q;
    disp_dat_d  = frame_start ? pend_dat_q : disp_dat_q;
    disp_dp_d   = frame_start ? pend_dp_q  : disp_dp_q;
  end

  // A zero digit is leading only while every digit from the top down to it is
  // zero with no decimal point lit; digit 0 is never suppressed.
  always_comb begin
    lz_run = 1'b1;
    blank  = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run   = lz_run & (disp_dat_q[4*k +: 4] == 4'h0) & ~disp_dp_q[k];
      blank[k] = blank_lz_i & lz_run;
    end
  end

  always_comb begin
    active_window = (cnt_q >= c_dead);
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_act    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == c_idx_w'(k)) begin
        cur_nib   = disp_dat_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = blank[k];
        an_act[k] = active_window;
      end
    end
    seg_act = cur_blank ? 7'b0 : hex_to_seg(cur_nib);
    an_d    = an_act ^ {N_DIGITS{c_pol}};
    seg_d   = seg_act ^ {7{c_pol}};
    dp_d    = (cur_dp & ~cur_blank) ^ c_pol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      first_q    <= 1'b1;
      pend_dat_q <= '0;
      pend_dp_q  <= '0;
      disp_dat_q <= '0;
      disp_dp_q  <= '0;
      an_q       <= {N_DIGITS{c_pol}};
      seg_q      <= {7{c_pol}};
      dp_q       <= c_pol;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      pend_dat_q <= pend_dat_d;
      pend_dp_q  <= pend_dp_d;
      disp_dat_q <= disp_dat_d;
      disp_dp_q  <= disp_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

`default_nettype wire
